// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, state encoding and helpers for the 4x4
// keypad scan controller.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;

    // Controller phases.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } kp_state_e;

    // Plain-vector copies of the state encoding. The state register is a
    // bare 2-bit vector so that the unused code 2'b11 stays representable
    // and can be recovered from.
    localparam logic [1:0] ST_SCAN     = SCAN;
    localparam logic [1:0] ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] ST_HOLD     = HOLD;

    localparam logic [ROWS-1:0] ROW_FIRST = 4'b0001;

    // Index of the lowest set bit. Returns 0 for an all-zero vector. Used
    // for column priority and to encode the one-hot row strobe.
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        if (vec[0]) begin
            idx = 2'd0;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: two-flop synchroniser for the asynchronous keypad
// column returns.
module keypad_col_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage synchroniser chain; the first stage may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row scanner, debouncer and key handshake for a 4x4
// keypad matrix. Rows are strobed one-hot; a column return freezes the
// scan, the key is debounced, accepted into a valid/ack holding register
// and then tracked until a debounced release.
//
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key is held, re-accept
// it after REPEAT_DELAY clocks and then every REPEAT_PERIOD clocks.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  col,
    output logic [ROWS-1:0]  row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             key_down,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_ZERO        = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    // Synchronised column levels; every decision below uses these only.
    logic [COLS-1:0] col_s;

    // Scan / debounce state.
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [ROWS-1:0]  row_q,     row_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic             key_down_q, key_down_d;

    // Consumer-facing key register.
    logic [KEY_W-1:0] key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             overrun_q,   overrun_d;

    // Pulses for one cycle when a key (or a repeat) is accepted.
    logic             accept_s;
    // Level of the latched column of the frozen row.
    logic             hit_s;
    // Row strobe rotated one position towards the last row, with wrap.
    logic [ROWS-1:0]  row_next_s;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
`endif

    keypad_col_sync #(
        .W (COLS)
    ) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (col),
        .q_o   (col_s)
    );

    assign hit_s      = col_s[col_idx_q];
    assign row_next_s = {row_q[ROWS-2:0], row_q[ROWS-1]};

    // Next-state logic for scanning, press debounce and release debounce.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        key_down_d = key_down_q;
        accept_s   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (col_s == 4'b0000) begin
                        row_d = row_next_s;
                    end else begin
                        // Freeze the strobe and remember which key answered.
                        row_idx_d = lowest_set_idx(row_q);
                        col_idx_d = lowest_set_idx(col_s);
                        state_d   = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (!hit_s) begin
                    // Bounce: abandon this key and carry on scanning.
                    state_d = ST_SCAN;
                    row_d   = row_next_s;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    accept_s   = 1'b1;
                    key_down_d = 1'b1;
                    state_d    = ST_HOLD;
                    cnt_d      = CNT_ZERO;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_d   = REP_ZERO;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Counter tracks consecutive released samples of the key.
                if (!hit_s) begin
                    if (cnt_q == DB_LAST) begin
                        key_down_d = 1'b0;
                        row_d      = row_next_s;
                        state_d    = ST_SCAN;
                        cnt_d      = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                // Repeat only while the key reads pressed; any released
                // sample restarts the initial delay.
                if (hit_s) begin
                    if ((rep_first_q && (rep_cnt_q == REP_DELAY_LAST)) ||
                        (!rep_first_q && (rep_cnt_q == REP_PERIOD_LAST))) begin
                        accept_s    = 1'b1;
                        rep_cnt_d   = REP_ZERO;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                    end
                end else begin
                    rep_cnt_d   = REP_ZERO;
                    rep_first_d = 1'b1;
                end
`endif
            end
            default: begin
                // Unused encoding: restart scanning from the first row.
                state_d    = ST_SCAN;
                cnt_d      = CNT_ZERO;
                row_d      = ROW_FIRST;
                key_down_d = 1'b0;
            end
        endcase
    end

    // Accept / acknowledge handling for the key holding register.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (accept_s) begin
            if (!key_valid_q || key_ack) begin
                // Slot free, or being freed this very cycle.
                key_code_d  = {row_idx_q, col_idx_q};
                key_valid_d = 1'b1;
                if (key_valid_q) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
            end else begin
                // Unconsumed key still present: keep it, flag the loss.
                overrun_d = 1'b1;
            end
        end else if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            cnt_q       <= CNT_ZERO;
            row_q       <= ROW_FIRST;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_down_q  <= 1'b0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_down_q  <= key_down_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= REP_ZERO;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign overrun   = overrun_q;

endmodule
